dcache_qspi: RTL and testbench

Line-transfer sequencer between the 4-line, 4-byte data cache and an external quad-SPI PSRAM. It accepts a line request from the cache's push/pull outputs, moves one 8-nibble line between a local buffer and the cache using back-to-back `rstrobe_d`/`wstrobe_d` bursts, and runs the matching QSPI write (`0x38`) or fast-read (`0xEB`) transaction on the pins. It sits directly downstream of the cache on its memory side.

---
 rtl/dcache_qspi.sv | 212 +++++++++++++++++++++
 tb/tb_dcache_qspi.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_qspi.sv
// dcache_qspi: moves one 8-nibble cache line between the data cache
// and a quad-SPI PSRAM, staging it in a local line buffer.
module dcache_qspi #(
  parameter int PA = 22,
  parameter logic [7:0] READ_CMD = 8'hEB,
  parameter logic [7:0] WRITE_CMD = 8'h38,
  parameter int READ_DUMMY = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          push,
  input  logic          pull,
  input  logic [PA-3:0] tag,
  input  logic [3:0]    dwrite,
  output logic [3:0]    dread,
  output logic          rstrobe_d,
  output logic          wstrobe_d,
  output logic          busy,
  output logic          done,
  output logic          spi_cs_n,
  output logic          spi_sck,
  output logic          spi_oe,
  output logic [3:0]    spi_dout,
  input  logic [3:0]    spi_din
);

  typedef enum logic [2:0] {
    IDLE,
    WCAP,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    FILL,
    DONE
  } state_t;

  localparam logic [3:0] DLAST = 4'(READ_DUMMY - 1);

  state_t        state;
  logic          phase;
  logic [3:0]    cnt;
  logic [2:0]    idx;
  logic          op;
  logic [PA-3:0] line;
  logic [3:0]    line_buf [8];

  logic [23:0]   addr;
  logic [3:0]    anib [6];
  logic [3:0]    cnt_nx;
  logic [2:0]    idx_nx;

  assign addr   = 24'({line, 2'b00});
  assign cnt_nx = cnt + 4'd1;
  assign idx_nx = idx + 3'd1;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      anib[i] = addr[23-4*i -: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      op        <= 1'b0;
      line      <= '0;
      for (int i = 0; i < 8; i++) begin
        line_buf[i] <= '0;
      end
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_oe    <= 1'b0;
      spi_dout  <= '0;
      rstrobe_d <= 1'b0;
      wstrobe_d <= 1'b0;
      dread     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && (push || pull)) begin
            line  <= tag;
            op    <= push;
            cnt   <= '0;
            idx   <= '0;
            phase <= 1'b0;
            busy  <= 1'b1;
            if (push) begin
              state     <= WCAP;
              rstrobe_d <= 1'b1;
            end else begin
              state    <= CMD;
              spi_cs_n <= 1'b0;
              spi_oe   <= 1'b1;
              spi_sck  <= 1'b0;
              spi_dout <= READ_CMD[7:4];
            end
          end
        end
        WCAP: begin
          line_buf[idx] <= dwrite;
          idx <= idx_nx;
          // strobe stays high all 8 cycles; the cache restarts its offset on a gap
          if (idx == 3'd7) begin
            rstrobe_d <= 1'b0;
            state     <= CMD;
            cnt       <= '0;
            phase     <= 1'b0;
            spi_cs_n  <= 1'b0;
            spi_oe    <= 1'b1;
            spi_sck   <= 1'b0;
            spi_dout  <= WRITE_CMD[7:4];
          end
        end
        FILL: begin
          if (idx == 3'd7) begin
            wstrobe_d <= 1'b0;
            dread     <= '0;
            idx       <= '0;
            state     <= DONE;
            done      <= 1'b1;
          end else begin
            idx   <= idx_nx;
            dread <= line_buf[idx_nx];
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          // beat: phase 0 sck low with new data, phase 1 sck high
          phase   <= ~phase;
          spi_sck <= ~phase;
          if (phase) begin
            unique case (state)
              CMD: begin
                if (cnt == 4'd0) begin
                  cnt      <= 4'd1;
                  spi_dout <= op ? WRITE_CMD[3:0]
                                 : READ_CMD[3:0];
                end else begin
                  cnt      <= '0;
                  state    <= ADDR;
                  spi_dout <= anib[0];
                end
              end
              ADDR: begin
                if (cnt == 4'd5) begin
                  cnt <= '0;
                  if (op) begin
                    state    <= DATA;
                    spi_dout <= line_buf[0];
                  end else begin
                    state    <= (READ_DUMMY == 0) ? DATA
                                                  : DUMMY;
                    spi_oe   <= 1'b0;
                    spi_dout <= '0;
                  end
                end else begin
                  cnt      <= cnt_nx;
                  spi_dout <= anib[cnt_nx[2:0]];
                end
              end
              DUMMY: begin
                if (cnt == DLAST) begin
                  cnt   <= '0;
                  state <= DATA;
                end else begin
                  cnt <= cnt_nx;
                end
              end
              DATA: begin
                if (!op) begin
                  line_buf[idx] <= spi_din;
                end
                if (idx == 3'd7) begin
                  idx      <= '0;
                  spi_cs_n <= 1'b1;
                  spi_oe   <= 1'b0;
                  spi_dout <= '0;
                  if (op) begin
                    state <= DONE;
                    done  <= 1'b1;
                  end else begin
                    state     <= FILL;
                    wstrobe_d <= 1'b1;
                    dread     <= line_buf[0];
                  end
                end else begin
                  idx <= idx_nx;
                  if (op) begin
                    spi_dout <= line_buf[idx_nx];
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_qspi.sv
// tb_dcache_qspi: scoreboard bench with cache and PSRAM models
// around dcache_qspi, plus a READ_DUMMY=4 copy for done timing.
module tb_dcache_qspi;

  localparam int PA  = 22;
  localparam int DMY = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          push = 1'b0;
  logic          pull = 1'b0;
  logic [PA-3:0] tag = '0;
  logic [3:0]    dwrite = '0;
  logic [3:0]    spi_din = '0;

  logic [3:0] dread, spi_dout;
  logic rstrobe_d, wstrobe_d, busy, done;
  logic spi_cs_n, spi_sck, spi_oe;

  logic [3:0] d2_dread, d2_dout;
  logic d2_rs, d2_ws, d2_busy, d2_done;
  logic d2_cs_n, d2_sck, d2_oe;

  always #5 clk = ~clk;

  dcache_qspi #(.PA(PA), .READ_DUMMY(DMY)) dut (
    .clk(clk), .reset(reset), .req(req),
    .push(push), .pull(pull), .tag(tag),
    .dwrite(dwrite), .dread(dread),
    .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d),
    .busy(busy), .done(done),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
    .spi_oe(spi_oe), .spi_dout(spi_dout),
    .spi_din(spi_din)
  );

  dcache_qspi #(.PA(PA), .READ_DUMMY(4)) dut4 (
    .clk(clk), .reset(reset), .req(req),
    .push(push), .pull(pull), .tag(tag),
    .dwrite(dwrite), .dread(d2_dread),
    .rstrobe_d(d2_rs), .wstrobe_d(d2_ws),
    .busy(d2_busy), .done(d2_done),
    .spi_cs_n(d2_cs_n), .spi_sck(d2_sck),
    .spi_oe(d2_oe), .spi_dout(d2_dout),
    .spi_din(spi_din)
  );

  typedef struct {
    string tg;
    int    kind;
    int    val;
    int    cyc;
  } ev_t;

  ev_t exp_q[$];
  int  d2_q[$];
  int  checks = 0;
  int  errors = 0;
  int  gcyc = 0;
  logic [3:0] rdata [8];
  logic [3:0] wdata [8];
  int  wk = 0;
  int  nrise = 0;
  int  j = 0;
  int  cs_hi = 100;
  logic sck_q = 1'b0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic check(input string t,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               t, obs, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [3:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check({e.tg, "_kind"}, kind, e.kind);
      check(e.tg, {28'd0, v}, e.val);
      check({e.tg, "_cyc"}, gcyc, e.cyc);
    end
  endtask

  // monitor, cache offset model and PSRAM model
  always @(negedge clk) begin
    if (reset) begin
      sck_q   = 1'b0;
      nrise   = 0;
      wk      = 0;
      dwrite  = '0;
      spi_din = '0;
    end else begin
      check("strobe_excl", {31'd0, rstrobe_d & wstrobe_d}, 0);
      if (spi_sck && !sck_q && !spi_cs_n && spi_oe)
        observe(0, spi_dout);
      if (wstrobe_d) observe(1, dread);
      if (done) observe(2, 4'h0);
      if (d2_done) begin
        if (d2_q.size() == 0)
          check("d2_unexpected_done", gcyc, -1);
        else
          check("d2_done_cyc", gcyc, d2_q.pop_front());
      end
      if (spi_cs_n) nrise = 0;
      else if (spi_sck && !sck_q) nrise++;
      if (!spi_sck) begin
        j = nrise - 8 - DMY;
        spi_din = (j >= 0 && j < 8) ? rdata[j] : 4'h0;
      end
      if (rstrobe_d) begin
        dwrite = (wk < 8) ? wdata[wk] : 4'h0;
        wk++;
      end else begin
        wk = 0;
      end
      if (spi_cs_n) begin
        cs_hi++;
      end else begin
        if (cs_hi > 0) check("cs_gap", {31'd0, cs_hi >= 2}, 1);
        cs_hi = 0;
      end
      sck_q = spi_sck;
    end
  end

  task automatic push_ev(input string t, input int k,
                         input int v, input int c);
    ev_t e;
    e.tg = t;
    e.kind = k;
    e.val = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_cmd_addr(input int base, input string p,
                              input logic [7:0] c,
                              input logic [PA-3:0] t);
    logic [23:0] a;
    a = {2'b00, t, 2'b00};
    push_ev({p, "_cmd_hi"}, 0, int'(c[7:4]), base + 2);
    push_ev({p, "_cmd_lo"}, 0, int'(c[3:0]), base + 4);
    for (int i = 0; i < 6; i++)
      push_ev($sformatf("%s_addr%0d", p, i), 0,
              int'(a[23-4*i -: 4]), base + 6 + 2*i);
  endtask

  task automatic exp_read(input int base,
                          input logic [PA-3:0] t,
                          input bit full);
    exp_cmd_addr(base, "rd", 8'hEB, t);
    if (full) begin
      for (int k = 0; k < 8; k++)
        push_ev($sformatf("fill%0d", k), 1,
                int'(rdata[k]), base + 45 + k);
      push_ev("rd_done", 2, 0, base + 53);
    end
  endtask

  task automatic exp_write(input int base,
                           input logic [PA-3:0] t);
    exp_cmd_addr(base + 8, "wr", 8'h38, t);
    for (int k = 0; k < 8; k++)
      push_ev($sformatf("wr_data%0d", k), 0,
              int'(wdata[k]), base + 26 + 2*k);
    push_ev("wr_done", 2, 0, base + 41);
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (gcyc < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_bound", {31'd0, gcyc >= target}, 1);
  endtask

  task automatic wait_done(input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", {31'd0, seen}, 1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_cs_n"}, spi_cs_n, 1);
    check({p, "_sck"}, spi_sck, 0);
    check({p, "_oe"}, spi_oe, 0);
    check({p, "_dout"}, spi_dout, 0);
    check({p, "_rstrobe"}, rstrobe_d, 0);
    check({p, "_wstrobe"}, wstrobe_d, 0);
    check({p, "_dread"}, dread, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
  endtask

  task automatic do_read(input logic [PA-3:0] t);
    int base;
    base = gcyc;
    exp_read(base, t, 1);
    d2_q.push_back(base + 49);
    req = 1'b1;
    pull = 1'b1;
    tag = t;
    check("pre_busy", busy, 0);
    @(negedge clk);
    req = 1'b0;
    pull = 1'b0;
    check("rd_busy", busy, 1);
    check("rd_cs_n", spi_cs_n, 0);
    wait_done(80);
    @(negedge clk);
    check("rd_idle", busy, 0);
  endtask

  task automatic do_write(input logic [PA-3:0] t);
    int base;
    base = gcyc;
    exp_write(base, t);
    d2_q.push_back(base + 41);
    req = 1'b1;
    push = 1'b1;
    tag = t;
    check("pre_busy", busy, 0);
    @(negedge clk);
    req = 1'b0;
    push = 1'b0;
    check("wr_busy", busy, 1);
    check("wr_rstrobe", rstrobe_d, 1);
    check("wr_cs_n", spi_cs_n, 1);
    wait_done(60);
    @(negedge clk);
    check("wr_idle", busy, 0);
  endtask

  initial begin
    int base;
    logic [3:0] wa [8];
    wa = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    @(negedge clk);
    check_reset("por");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) rdata[k] = 4'(k + 1);
    do_read(20'h12345);

    wdata = wa;
    do_write(20'h3C3C3);

    // push+pull together, req held through DONE, tag moved mid-write
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 4'(k + 5);
      rdata[k] = 4'(15 - k);
    end
    base = gcyc;
    exp_write(base, 20'hFEDCB);
    exp_read(base + 42, 20'h00F0F, 1);
    d2_q.push_back(base + 41);
    d2_q.push_back(base + 91);
    req = 1'b1;
    push = 1'b1;
    pull = 1'b1;
    tag = 20'hFEDCB;
    wait_cyc(base + 5);
    tag = 20'h00F0F;
    wait_cyc(base + 20);
    push = 1'b0;
    wait_cyc(base + 41);
    check("chain_done_busy", busy, 1);
    wait_cyc(base + 43);
    req = 1'b0;
    pull = 1'b0;
    check("chain_busy", busy, 1);
    check("chain_cs_n", spi_cs_n, 0);
    wait_done(80);
    @(negedge clk);

    // reset in cycle 30 of a read
    for (int k = 0; k < 8; k++) rdata[k] = 4'(k + 8);
    base = gcyc;
    exp_read(base, 20'h55AA5, 0);
    req = 1'b1;
    pull = 1'b1;
    tag = 20'h55AA5;
    @(negedge clk);
    req = 1'b0;
    pull = 1'b0;
    wait_cyc(base + 30);
    reset = 1'b1;
    #1;
    check_reset("mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_queue", exp_q.size(), 0);
    for (int i = 0; i < 12; i++) @(negedge clk);

    rdata = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};
    do_read(20'h0A0A0);

    for (int i = 0; i < 10; i++) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("d2_q_empty", d2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
